// File: rtl/bcd_scan_counter_pkg.sv
// Shared types and constants for the four-digit BCD stopwatch counter and its
// multiplexed digit scanner.
package bcd_scan_counter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_e;

   localparam int NUM_DIGITS = 4;
   localparam int BCD_W      = 4;
   localparam int SCAN_IDX_W = $clog2(NUM_DIGITS);

   localparam logic [NUM_DIGITS-1:0] DIG_SEL_RESET = 4'b1110;

   typedef logic [BCD_W-1:0] bcd_t;

   // Active-low one-hot enable for the digit at position idx (0 = ones).
   function automatic logic [NUM_DIGITS-1:0] dig_sel_of(input logic [SCAN_IDX_W-1:0] idx);
      return ~(NUM_DIGITS'(1) << idx);
   endfunction

endpackage

// File: rtl/bcd_scan_counter_if.sv
// Control inputs and display outputs of the BCD scan counter, bundled so the
// counter and whatever drives it share one port list.
interface bcd_scan_counter_if;
   import bcd_scan_counter_pkg::*;

   logic                  start_stop;
   logic                  clear;
   bcd_t                  num;
   logic [NUM_DIGITS-1:0] dig_sel;
   logic                  running;
   logic                  overflow;

   modport master (
      output start_stop,
      output clear,
      input  num,
      input  dig_sel,
      input  running,
      input  overflow
   );

   modport slave (
      input  start_stop,
      input  clear,
      output num,
      output dig_sel,
      output running,
      output overflow
   );

endinterface

// File: rtl/bcd_scan_counter_digit.sv
// One decade of the BCD counter: counts 0..9 on inc and emits a carry on the
// increment that wraps it back to 0.
module bcd_digit
   import bcd_scan_counter_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   output bcd_t digit,
   output logic carry
);

   localparam bcd_t BCD_MAX = BCD_W'(9);

   bcd_t digit_q;
   bcd_t digit_d;

   assign carry = inc & (digit_q == BCD_MAX);

   always_comb begin
      digit_d = digit_q;
      if (clr) begin
         digit_d = '0;
      end else if (inc) begin
         digit_d = (digit_q == BCD_MAX) ? '0 : digit_q + BCD_W'(1);
      end
   end

   // NOTE: state registers use non-blocking assignment so every flop samples
   // the pre-edge values of its neighbours, regardless of block ordering.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         digit_q <= '0;
      end else begin
         digit_q <= digit_d;
      end
   end

   assign digit = digit_q;

endmodule

// File: rtl/bcd_scan_counter.sv
// Four-digit BCD stopwatch with start/stop/clear control and a free-running
// scanner presenting one registered digit per scan slot for a 7-seg decoder.
module bcd_scan_counter
   import bcd_scan_counter_pkg::*;
#(
   parameter int TICK_DIV = 50_000_000,
   parameter int SCAN_DIV = 50_000
) (
   input  logic               clk,
   input  logic               rst_n,
   bcd_scan_counter_if.slave  bus
);

   localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

   // Control path
   logic                    ss_q;
   logic                    req;
   state_e                  state_q;
   state_e                  state_d;
   logic                    running_q;
   logic [TICK_W-1:0]       presc_q;
   logic [TICK_W-1:0]       presc_d;
   logic                    tick;

   // Count chain
   logic [NUM_DIGITS-1:0]             inc;
   logic [NUM_DIGITS-1:0]             carry;
   logic [NUM_DIGITS-1:0][BCD_W-1:0]  digits;
   logic                              overflow_q;

   // Scanner
   logic [SCAN_W-1:0]       scan_cnt_q;
   logic [SCAN_W-1:0]       scan_cnt_d;
   logic [SCAN_IDX_W-1:0]   scan_idx_q;
   logic [SCAN_IDX_W-1:0]   scan_idx_d;
   bcd_t                    num_q;
   logic [NUM_DIGITS-1:0]   dig_sel_q;

   assign req = bus.start_stop & ~ss_q;

   // NOTE: every variable gets a default at the top of always_comb so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:   if (req) state_d = ST_PAUSE;
         ST_PAUSE: if (req) state_d = ST_RUN;
         default:  state_d = req ? ST_RUN : ST_IDLE;
      endcase
      if (bus.clear) begin
         state_d = ST_IDLE;
      end
   end

   always_comb begin
      presc_d = presc_q;
      tick    = 1'b0;
      if (bus.clear) begin
         presc_d = '0;
      end else if (state_q == ST_RUN) begin
         if (presc_q == TICK_LAST) begin
            presc_d = '0;
            tick    = 1'b1;
         end else begin
            presc_d = presc_q + TICK_W'(1);
         end
      end
   end

   assign inc[0] = tick;

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
      bcd_digit u_digit (
         .clk   (clk),
         .rst_n (rst_n),
         .clr   (bus.clear),
         .inc   (inc[i]),
         .digit (digits[i]),
         .carry (carry[i])
      );
      if (i < NUM_DIGITS - 1) begin : g_chain
         assign inc[i+1] = carry[i];
      end
   end

   always_comb begin
      scan_cnt_d = scan_cnt_q + SCAN_W'(1);
      scan_idx_d = scan_idx_q;
      if (scan_cnt_q == SCAN_LAST) begin
         scan_cnt_d = '0;
         scan_idx_d = scan_idx_q + SCAN_IDX_W'(1);
      end
   end

   // num is taken from the pre-edge count at the slot being selected, so it
   // always matches dig_sel and lags a count change by at most one edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ss_q       <= 1'b0;
         state_q    <= ST_IDLE;
         running_q  <= 1'b0;
         presc_q    <= '0;
         overflow_q <= 1'b0;
         scan_cnt_q <= '0;
         scan_idx_q <= '0;
         num_q      <= '0;
         dig_sel_q  <= DIG_SEL_RESET;
      end else begin
         ss_q       <= bus.start_stop;
         state_q    <= state_d;
         running_q  <= (state_d == ST_RUN);
         presc_q    <= presc_d;
         overflow_q <= carry[NUM_DIGITS-1];
         scan_cnt_q <= scan_cnt_d;
         scan_idx_q <= scan_idx_d;
         num_q      <= digits[scan_idx_d];
         dig_sel_q  <= dig_sel_of(scan_idx_d);
      end
   end

   assign bus.num      = num_q;
   assign bus.dig_sel  = dig_sel_q;
   assign bus.running  = running_q;
   assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Bench for bcd_scan_counter: an integer-arithmetic stopwatch model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_bcd_scan_counter;
   import bcd_scan_counter_pkg::*;

   localparam int TICK_DIV = 4;
   localparam int SCAN_DIV = 2;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;

   localparam int          POW10   [4] = '{1, 10, 100, 1000};
   localparam logic [3:0]  SEL_TAB [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   bcd_scan_counter_if bus ();

   bcd_scan_counter #(
      .TICK_DIV (TICK_DIV),
      .SCAN_DIV (SCAN_DIV)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Stopwatch model: count as a plain integer, ticks every TICK_DIV running
   // cycles, display slot derived from cycles elapsed since reset.
   int         m_mode  = M_IDLE;
   int         m_count = 0;
   int         m_phase = 0;
   int         m_cyc   = 0;
   int         m_num   = 0;
   int         m_pos   = 0;
   bit         m_prev  = 1'b0;
   bit         m_req   = 1'b0;
   bit         m_ovf   = 1'b0;
   bit         m_valid = 1'b0;
   logic [3:0] m_sel   = 4'b1110;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_mode  = M_IDLE;
         m_count = 0;
         m_phase = 0;
         m_cyc   = 0;
         m_prev  = 1'b0;
         m_ovf   = 1'b0;
         m_num   = 0;
         m_sel   = 4'b1110;
         m_valid = 1'b1;
      end else begin
         m_req  = bus.start_stop && !m_prev;
         m_prev = bus.start_stop;
         m_cyc++;
         m_pos  = (m_cyc / SCAN_DIV) % 4;
         m_sel  = SEL_TAB[m_pos];
         m_num  = (m_count / POW10[m_pos]) % 10;
         m_ovf  = 1'b0;
         if (bus.clear) begin
            m_mode  = M_IDLE;
            m_count = 0;
            m_phase = 0;
         end else begin
            if (m_mode == M_RUN) begin
               m_phase++;
               if (m_phase == TICK_DIV) begin
                  m_phase = 0;
                  m_count++;
                  if (m_count == 10000) begin
                     m_count = 0;
                     m_ovf   = 1'b1;
                  end
               end
            end
            if (m_req) m_mode = (m_mode == M_RUN) ? M_PAUSE : M_RUN;
         end
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("num",      32'(bus.num),      32'(m_num));
         check("dig_sel",  32'(bus.dig_sel),  32'(m_sel));
         check("running",  32'(bus.running),  32'(m_mode == M_RUN));
         check("overflow", 32'(bus.overflow), 32'(m_ovf));
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start();
      bus.start_stop = 1'b1;
      cycles(1);
      bus.start_stop = 1'b0;
   endtask

   task automatic wait_count(input int target, input int budget, input string name);
      int n = 0;
      while (m_count != target && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(m_count), 32'(target));
   endtask

   // Reassembles the four-digit value from one full scan of the display.
   task automatic check_display(input int exp, input string name);
      int dig [4];
      int got;
      for (int i = 0; i < 4; i++) dig[i] = 15;
      repeat (8) begin
         @(negedge clk);
         case (bus.dig_sel)
            4'b1110: dig[0] = int'(bus.num);
            4'b1101: dig[1] = int'(bus.num);
            4'b1011: dig[2] = int'(bus.num);
            4'b0111: dig[3] = int'(bus.num);
            default: ;
         endcase
      end
      got = dig[0] + 10 * dig[1] + 100 * dig[2] + 1000 * dig[3];
      check(name, 32'(got), 32'(exp));
   endtask

   initial begin
      int ovf_seen;
      bus.start_stop = 1'b0;
      bus.clear      = 1'b0;
      rst_n          = 1'b0;
      cycles(3);
      check("rst_dig_sel", 32'(bus.dig_sel), 32'(4'b1110));
      check("rst_num",     32'(bus.num),     32'd0);
      check("rst_running", 32'(bus.running), 32'd0);
      rst_n = 1'b1;

      // Scanner walks 1110, 1101, 1011, 0111, 1110 with two cycles per slot.
      for (int i = 0; i < 8; i++) begin
         cycles(1);
         check("scan_seq", 32'(bus.dig_sel), 32'(SEL_TAB[((i + 1) / 2) % 4]));
         check("scan_num", 32'(bus.num), 32'd0);
      end

      // Start, holding start_stop high for 20 cycles: a single request only.
      bus.start_stop = 1'b1;
      cycles(1);
      check("start_running", 32'(bus.running), 32'd1);
      for (int i = 0; i < 19; i++) begin
         cycles(1);
         check("hold_no_toggle", 32'(bus.running), 32'd1);
      end
      bus.start_stop = 1'b0;
      cycles(21);
      check("count_after_40", 32'(m_count), 32'd10);
      check("still_running",  32'(bus.running), 32'd1);

      // Clear back to idle, then pause at 0007 and resume.
      bus.clear = 1'b1;
      cycles(1);
      bus.clear = 1'b0;
      check("clear_running", 32'(bus.running), 32'd0);
      pulse_start();
      wait_count(7, 100, "reach_7");
      pulse_start();
      check("pause_running", 32'(bus.running), 32'd0);
      cycles(100);
      check("pause_frozen", 32'(m_count), 32'd7);
      check_display(7, "pause_display");
      pulse_start();
      check("resume_running", 32'(bus.running), 32'd1);
      wait_count(8, 4, "resume_reach_8");

      // Full-scale wrap from 0000 to 9999 and over.
      bus.clear = 1'b1;
      cycles(1);
      bus.clear = 1'b0;
      pulse_start();
      wait_count(9999, 9999 * TICK_DIV + 20, "reach_9999");
      ovf_seen = 0;
      for (int i = 0; i < 12; i++) begin
         cycles(1);
         if (bus.overflow === 1'b1) ovf_seen++;
      end
      check("overflow_pulses", 32'(ovf_seen), 32'd1);
      check("wrap_count",      32'(m_count), 32'd2);
      check("wrap_running",    32'(bus.running), 32'd1);

      // Clear and a start_stop rising edge together: clear wins.
      bus.clear = 1'b1;
      cycles(1);
      bus.clear = 1'b0;
      pulse_start();
      wait_count(123, 124 * TICK_DIV + 20, "reach_123");
      bus.clear      = 1'b1;
      bus.start_stop = 1'b1;
      cycles(1);
      bus.clear = 1'b0;
      check("clr_prio_running", 32'(bus.running), 32'd0);
      check("clr_prio_count",   32'(m_count), 32'd0);
      cycles(1);
      bus.start_stop = 1'b0;
      check_display(0, "clr_prio_display");
      pulse_start();
      check("restart_running", 32'(bus.running), 32'd1);
      check("restart_count",   32'(m_count), 32'd0);

      // Reset in the middle of a run.
      wait_count(456, 457 * TICK_DIV + 20, "reach_456");
      rst_n = 1'b0;
      cycles(1);
      check("mid_rst_dig_sel",  32'(bus.dig_sel),  32'(4'b1110));
      check("mid_rst_num",      32'(bus.num),      32'd0);
      check("mid_rst_running",  32'(bus.running),  32'd0);
      check("mid_rst_overflow", 32'(bus.overflow), 32'd0);
      rst_n = 1'b1;
      cycles(1);
      check("mid_rst_scan0", 32'(bus.dig_sel), 32'(4'b1110));
      cycles(1);
      check("mid_rst_scan1", 32'(bus.dig_sel), 32'(4'b1101));
      check("mid_rst_idle",  32'(bus.running), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench did not finish in time");
   end

endmodule
